// File: rtl/regfile_pkg.sv
// Shared constants, FSM state encoding and reset preload for the 16x8 register file and its sorter.
// No logic and no timing of its own; it only supplies types and values.
package regfile_pkg;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CMP, WR_LO, WR_HI, NEXT, DONE
  } state_t;

  function automatic logic [WIDTH-1:0] preset_val(input logic [ADDR_W-1:0] idx);
    logic [WIDTH-1:0] v;
    case (idx)
      4'd0:    v = 8'd254;
      4'd1:    v = 8'd169;
      4'd2:    v = 8'd156;
      4'd3:    v = 8'd250;
      4'd4:    v = 8'd145;
      4'd5:    v = 8'd247;
      4'd6:    v = 8'd128;
      4'd7:    v = 8'd232;
      4'd8:    v = 8'd249;
      4'd9:    v = 8'd105;
      4'd10:   v = 8'd189;
      4'd11:   v = 8'd172;
      4'd12:   v = 8'd65;
      4'd13:   v = 8'd180;
      4'd14:   v = 8'd218;
      default: v = 8'd39;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/Register16_8.sv
// 16x8 register file: combinational read (zero when R_en is low), write on posedge.
// Every access completes in the cycle it is issued; there is no backpressure. Rst reloads the preset.
module Register16_8
  import regfile_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] R_Addr,
  input  logic              R_en,
  output logic [WIDTH-1:0]  R_Data,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic              W_en,
  input  logic [WIDTH-1:0]  W_Data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= preset_val(ADDR_W'(j));
    end else if (W_en) begin
      mem[W_Addr] <= W_Data;
    end
  end

  assign R_Data = R_en ? mem[R_Addr] : '0;

endmodule

// File: rtl/regfile_sorter.sv
// In-place ascending bubble sort over the register file: 4 cycles per compare, 6 when it swaps.
// Start is taken only in IDLE and never queued; all bus outputs are registered and zero when disabled.
module regfile_sorter
  import regfile_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [7:0]        SwapCount,
  output logic [ADDR_W-1:0] R_Addr,
  output logic              R_en,
  input  logic [WIDTH-1:0]  R_Data,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              W_en,
  output logic [WIDTH-1:0]  W_Data
);

  localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(DEPTH - 2);

  state_t            state;
  logic [ADDR_W-1:0] p, i;
  logic [WIDTH-1:0]  a, b;
  logic              swapped;
  logic [ADDR_W-1:0] last_idx;

  // Highest i compared in this pass; the tail above it is already in place.
  assign last_idx = LAST_P - p;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      p         <= '0;
      i         <= '0;
      a         <= '0;
      b         <= '0;
      swapped   <= 1'b0;
      SwapCount <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      R_Addr    <= '0;
      R_en      <= 1'b0;
      W_Addr    <= '0;
      W_en      <= 1'b0;
      W_Data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            p         <= '0;
            i         <= '0;
            swapped   <= 1'b0;
            SwapCount <= '0;
            Busy      <= 1'b1;
            R_en      <= 1'b1;
            R_Addr    <= '0;
            state     <= RD_A;
          end
        end
        RD_A: begin
          a      <= R_Data;
          R_Addr <= i + 1'b1;
          state  <= RD_B;
        end
        RD_B: begin
          b      <= R_Data;
          R_en   <= 1'b0;
          R_Addr <= '0;
          state  <= CMP;
        end
        CMP: begin
          if (a > b) begin
            W_en   <= 1'b1;
            W_Addr <= i;
            W_Data <= b;
            state  <= WR_LO;
          end else begin
            state  <= NEXT;
          end
        end
        WR_LO: begin
          W_Addr <= i + 1'b1;
          W_Data <= a;
          state  <= WR_HI;
        end
        WR_HI: begin
          swapped   <= 1'b1;
          SwapCount <= SwapCount + 1'b1;
          W_en      <= 1'b0;
          W_Addr    <= '0;
          W_Data    <= '0;
          state     <= NEXT;
        end
        NEXT: begin
          if (i < last_idx) begin
            i      <= i + 1'b1;
            R_en   <= 1'b1;
            R_Addr <= i + 1'b1;
            state  <= RD_A;
          end else if (!swapped || p == LAST_P) begin
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            p       <= p + 1'b1;
            i       <= '0;
            swapped <= 1'b0;
            R_en    <= 1'b1;
            R_Addr  <= '0;
            state   <= RD_A;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sorter.sv
// Sorter plus register file on a shared bus; bench can take over both file ports while the sorter idles.
// Each sort pushes a modelled result to a queue that is popped when Done appears.
module tb_regfile_sorter;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       Busy, Done;
  logic [7:0] SwapCount;
  logic [3:0] R_Addr, W_Addr;
  logic       R_en, W_en;
  logic [7:0] R_Data, W_Data;

  logic       tb_own = 1'b0;
  logic [3:0] tb_r_addr = '0, tb_w_addr = '0;
  logic       tb_r_en = 1'b0, tb_w_en = 1'b0;
  logic [7:0] tb_w_dat = '0;

  logic [3:0] f_r_addr, f_w_addr;
  logic       f_r_en, f_w_en;
  logic [7:0] f_w_dat;

  assign f_r_addr = tb_own ? tb_r_addr : R_Addr;
  assign f_r_en   = tb_own ? tb_r_en   : R_en;
  assign f_w_addr = tb_own ? tb_w_addr : W_Addr;
  assign f_w_en   = tb_own ? tb_w_en   : W_en;
  assign f_w_dat  = tb_own ? tb_w_dat  : W_Data;

  regfile_sorter dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .Done(Done), .SwapCount(SwapCount),
    .R_Addr(R_Addr), .R_en(R_en), .R_Data(R_Data),
    .W_Addr(W_Addr), .W_en(W_en), .W_Data(W_Data)
  );

  Register16_8 rf (
    .Clk(Clk), .Rst(Rst), .R_Addr(f_r_addr), .R_en(f_r_en), .R_Data(R_Data),
    .W_Addr(f_w_addr), .W_en(f_w_en), .W_Data(f_w_dat)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0][7:0] data;
    logic [7:0]       swaps;
    logic [15:0]      lat;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  int   mon_done, mon_wr, mon_busy, mon_dec, mon_idle_bad;
  logic prev_busy = 1'b0;
  logic [7:0] prev_sc = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Done) mon_done++;
    if (W_en) mon_wr++;
    if (Busy) mon_busy++;
    if (Busy && prev_busy && SwapCount < prev_sc) mon_dec++;
    if ((!W_en && (W_Addr != 0 || W_Data != 0)) || (!R_en && R_Addr != 0)) mon_idle_bad++;
    prev_busy = Busy;
    prev_sc   = SwapCount;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference bubble sort with early exit; cycle cost is 4 per compare plus 2 per swap.
  task automatic model(input logic [15:0][7:0] init, output exp_t e);
    logic [7:0] m [16];
    logic [7:0] t;
    int sw, cmp, p;
    bit fl, fin;
    for (int j = 0; j < 16; j++) m[j] = init[j];
    sw = 0; cmp = 0; p = 0; fin = 0;
    while (!fin) begin
      fl = 0;
      for (int j = 0; j <= 14 - p; j++) begin
        cmp++;
        if (m[j] > m[j+1]) begin
          t = m[j]; m[j] = m[j+1]; m[j+1] = t;
          sw++; fl = 1;
        end
      end
      if (!fl || p == 14) fin = 1;
      else p++;
    end
    for (int j = 0; j < 16; j++) e.data[j] = m[j];
    e.swaps = sw[7:0];
    e.lat   = 16'(cmp * 4 + sw * 2 + 1);
  endtask

  task automatic load(input logic [15:0][7:0] d);
    tb_own = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tb_w_addr = j[3:0];
      tb_w_dat  = d[j];
      tb_w_en   = 1'b1;
      @(posedge Clk); #1;
    end
    tb_w_en = 1'b0;
    tb_own  = 1'b0;
  endtask

  task automatic run_sort(input string name, input logic [15:0][7:0] init, input bit spam);
    exp_t e;
    int k, dcyc;
    bit got;
    model(init, e);
    sb.push_back(e);
    @(posedge Clk); #1;
    mon_done = 0; mon_wr = 0; mon_busy = 0; mon_dec = 0; mon_idle_bad = 0;
    Start = 1'b1;
    k = cyc + 1;
    @(posedge Clk); #1;
    Start = 1'b0;
    got = 0; dcyc = 0;
    for (int t = 0; t < 2000 && !got; t++) begin
      @(negedge Clk);
      if (spam && t < 100) Start = (t % 3 == 0);
      else Start = 1'b0;
      if (Done) begin got = 1; dcyc = cyc + 1; end
    end
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    e = sb.pop_front();
    check({name, " done_seen"}, int'(got), 1);
    if (got) check({name, " done_latency"}, dcyc - k, int'(e.lat));
    check({name, " swap_count"}, int'(SwapCount), int'(e.swaps));
    check({name, " done_pulses"}, mon_done, 1);
    check({name, " write_cycles"}, mon_wr, 2 * int'(e.swaps));
    check({name, " busy_cycles"}, mon_busy, int'(e.lat));
    check({name, " busy_after"}, int'(Busy), 0);
    check({name, " swap_monotonic"}, mon_dec, 0);
    check({name, " idle_bus_zero"}, mon_idle_bad, 0);
    tb_own = 1'b1; tb_r_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tb_r_addr = j[3:0];
      #1;
      check($sformatf("%s data[%0d]", name, j), int'(R_Data), int'(e.data[j]));
    end
    tb_r_en = 1'b0; tb_own = 1'b0;
  endtask

  initial begin
    int pv [16] = '{254, 169, 156, 250, 145, 247, 128, 232, 249, 105, 189, 172, 65, 180, 218, 39};
    logic [15:0][7:0] pre, asc, desc, flat;
    for (int j = 0; j < 16; j++) begin
      pre[j]  = pv[j][7:0];
      asc[j]  = j[7:0];
      desc[j] = 8'(15 - j);
      flat[j] = 8'hAA;
    end

    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("rst busy", int'(Busy), 0);
    check("rst done", int'(Done), 0);
    check("rst swapcount", int'(SwapCount), 0);
    check("rst r_en", int'(R_en), 0);
    check("rst w_en", int'(W_en), 0);

    run_sort("preset", pre, 1'b0);
    check("preset swaps_79", int'(SwapCount), 79);

    load(asc);
    run_sort("ascending", asc, 1'b0);
    check("ascending swaps_0", int'(SwapCount), 0);

    load(desc);
    run_sort("descending", desc, 1'b0);
    check("descending swaps_120", int'(SwapCount), 120);

    load(flat);
    run_sort("all_aa", flat, 1'b0);

    load(pre);
    run_sort("start_spam", pre, 1'b1);

    // Abort a sort 100 cycles in; the file reloads its preset on the same edge.
    load(desc);
    @(posedge Clk); #1;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (99) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("midrst busy", int'(Busy), 0);
    check("midrst done", int'(Done), 0);
    check("midrst swapcount", int'(SwapCount), 0);
    check("midrst r_en", int'(R_en), 0);
    check("midrst w_en", int'(W_en), 0);
    check("midrst r_addr", int'(R_Addr), 0);
    run_sort("after_rst", pre, 1'b0);
    check("after_rst swaps_79", int'(SwapCount), 79);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
